// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation codes, FSM states
// and the per-cycle step limit derived from the step-field width.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic int max_step(input int step_bits);
        return (1 << step_bits) - 1;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by 0..2^STEP_BITS-1 positions
// in one of four modes, each result bit picked from a small per-bit mux.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH     = 65,
    parameter int STEP_BITS = 2
) (
    input  logic [WIDTH-1:0]     data,
    input  logic [1:0]           op,
    input  logic [STEP_BITS-1:0] amount,
    output logic [WIDTH-1:0]     result
);

    localparam int NSEL = 1 << STEP_BITS;

    // For every output bit, each candidate amount names its source bit; the
    // amount field then picks one candidate, the same shape as an mx4 row.
    always_comb begin
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int a = 0; a < NSEL; a++) begin
                if (amount == STEP_BITS'(a)) begin
                    case (op)
                        OP_LSL:  result[i] = (i >= a) ? data[i - a] : 1'b0;
                        OP_LSR:  result[i] = (i + a < WIDTH) ? data[i + a] : 1'b0;
                        OP_ASR:  result[i] = (i + a < WIDTH) ? data[i + a] : data[WIDTH - 1];
                        default: result[i] = data[(i + a) % WIDTH];
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter with start/busy/done handshake; reuses
// one small step shifter, applying at most MAXSTEP positions per cycle.
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int WIDTH     = 65,
    parameter int STEP_BITS = 2,
    parameter int SHAMT_W   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   d_out
);

    localparam logic [SHAMT_W:0] WIDTH_EXT = (SHAMT_W + 1)'(WIDTH);
    localparam logic [SHAMT_W:0] MAX_REM   = (SHAMT_W + 1)'(max_step(STEP_BITS));

    state_e               state;
    state_e               next_state;
    logic [SHAMT_W:0]     rem;
    logic [SHAMT_W:0]     rem_next;
    logic [SHAMT_W:0]     shamt_ext;
    logic [SHAMT_W:0]     eff;
    logic [STEP_BITS-1:0] step;
    logic [WIDTH-1:0]     work;
    logic [WIDTH-1:0]     step_out;
    logic [1:0]           op_q;
    logic                 accept;

    shift_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .data   (work),
        .op     (op_q),
        .amount (step),
        .result (step_out)
    );

    // One conditional subtract suffices for ROR because shamt < 2*WIDTH.
    always_comb begin
        shamt_ext = {1'b0, shamt};
        eff       = shamt_ext;
        if (op == OP_ROR) begin
            if (shamt_ext >= WIDTH_EXT) eff = shamt_ext - WIDTH_EXT;
        end else if (shamt_ext > WIDTH_EXT) begin
            eff = WIDTH_EXT;
        end
    end

    always_comb begin
        accept     = start && (state == ST_IDLE || state == ST_DONE);
        step       = (rem > MAX_REM) ? STEP_BITS'(MAX_REM) : rem[STEP_BITS-1:0];
        rem_next   = rem - (SHAMT_W + 1)'(step);
        next_state = state;
        case (state)
            ST_SHIFT: if (rem_next == '0) next_state = ST_DONE;
            ST_IDLE,
            ST_DONE: begin
                if (accept)                 next_state = (eff == '0) ? ST_DONE : ST_SHIFT;
                else if (state == ST_DONE)  next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            rem   <= '0;
            work  <= '0;
            op_q  <= '0;
            d_out <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                work  <= d_in;
                d_out <= d_in;
                op_q  <= op;
                rem   <= eff;
            end else if (state == ST_SHIFT) begin
                work <= step_out;
                rem  <= rem_next;
                if (rem_next == '0) d_out <= step_out;
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_unit_iter.sv
// Randomised self-checking bench for shift_unit_iter against a plain
// arithmetic model of the four shift modes and the handshake latency.
module tb_shift_unit_iter;

    localparam int W  = 65;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  d_in;
    logic [SW-1:0] shamt;
    logic          busy;
    logic          done;
    logic [W-1:0]  d_out;

    int check_count = 0;
    int pass_count  = 0;

    shift_unit_iter #(.WIDTH(W), .STEP_BITS(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .d_in    (d_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .d_out   (d_out)
    );

    always #5 clk = ~clk;

    // Reference result straight from the shift definitions.
    function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] d, input int sh);
        logic signed [W-1:0] s;
        int r;
        s = d;
        case (o)
            2'd0:    return (sh >= W) ? '0 : d << sh;
            2'd1:    return (sh >= W) ? '0 : d >> sh;
            2'd2:    return (sh >= W) ? {W{d[W-1]}} : W'(s >>> sh);
            default: begin
                r = sh % W;
                return (r == 0) ? d : ((d >> r) | (d << (W - r)));
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input int sh);
        int eff;
        eff = (o == 2'd3) ? sh % W : ((sh > W) ? W : sh);
        return (eff == 0) ? 1 : 1 + (eff + 2) / 3;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_count++;
        if (obs === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one request at a negedge; accepted on the following rising edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] d, input int sh);
        op    = o;
        d_in  = d;
        shamt = SW'(sh);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done, checking latency, busy length, d_out hold and result.
    task automatic waitResult(input logic [1:0] o, input logic [W-1:0] d, input int sh,
                              input bit noise, input bit keep_start);
        int cycles   = 1;
        int busy_cnt = 0;
        bit seen     = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            checkOutput("hold", d_out, d);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom);
                d_in  = {1'($urandom), $urandom(), $urandom()};
                shamt = SW'($urandom);
            end
            cycles++;
        end
        if (!keep_start) start = 1'b0;
        checkOutput("done", done, 1'b1);
        if (seen) begin
            checkOutput("latency", cycles, ref_latency(o, sh));
            checkOutput("busy_len", busy_cnt, ref_latency(o, sh) - 1);
        end
        checkOutput("result", d_out, ref_shift(o, d, sh));
    endtask

    task automatic runOp(input logic [1:0] o, input logic [W-1:0] d, input int sh, input bit noise);
        applyStimulus(o, d, sh);
        waitResult(o, d, sh, noise, 1'b0);
        @(negedge clk);
        checkOutput("pulse", done, 1'b0);
        checkOutput("keep", d_out, ref_shift(o, d, sh));
    endtask

    initial begin
        logic [W-1:0] msb;
        logic [W-1:0] one;
        logic [W-1:0] rd;
        logic [1:0]   ro;
        int           rs;
        msb     = {1'b1, 64'd0};
        one     = W'(1);
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        d_in    = '0;
        shamt   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_dout", d_out, '0);
        reset_n = 1'b1;

        runOp(2'd2, msb, 4, 1'b0);
        runOp(2'd1, msb, 4, 1'b0);
        runOp(2'd3, one, 1, 1'b0);
        runOp(2'd0, one, 64, 1'b0);
        for (int o = 0; o < 4; o++) runOp(2'(o), {1'b1, 64'h0123_4567_89AB_CDEF}, 0, 1'b0);
        runOp(2'd0, '1, 100, 1'b0);
        runOp(2'd2, msb, 100, 1'b0);
        runOp(2'd3, one, 100, 1'b0);
        runOp(2'd1, '1, 65, 1'b0);
        runOp(2'd3, one, 127, 1'b0);

        // Requests while busy must be ignored.
        runOp(2'd3, {1'b0, 64'hDEAD_BEEF_0000_FFFF}, 37, 1'b1);
        runOp(2'd2, {1'b1, 64'h8000_0000_0000_0001}, 50, 1'b1);

        // start held through DONE: back-to-back acceptance.
        applyStimulus(2'd1, '1, 5);
        start = 1'b1;
        waitResult(2'd1, '1, 5, 1'b0, 1'b1);
        applyStimulus(2'd0, one, 2);
        waitResult(2'd0, one, 2, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("b2b_pulse", done, 1'b0);

        // Reset in the middle of a shift discards the operation.
        applyStimulus(2'd0, one, 64);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_done", done, 1'b0);
        checkOutput("mid_rst_dout", d_out, '0);
        reset_n = 1'b1;
        runOp(2'd2, msb, 7, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom);
            rd = {1'($urandom), $urandom(), $urandom()};
            rs = int'($urandom_range(0, 127));
            runOp(ro, rd, rs, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
